// File: rtl/ft245_tx.sv
// ft245_tx: pulls words from the async FIFO read port and drives the FT245
// synchronous-FIFO write bus (TXE#/WR#/DATA) in the FT245 clock domain.
// A 3-deep skid queue absorbs the FIFO read latency and the TXE#-retry rule
// while still sustaining one word per clock.
// Optional send-immediate flush (SIWU#): define FT245_TX_SIWU_EN.
//
// Handshakes:
//   FIFO side : a read is accepted when fifo_ren=1 and fifo_rempty=0 at a
//               posedge; the word arrives with fifo_rvalid=1 exactly one clk
//               later and is always pushed (room was reserved at issue).
//   FT245 side: WR# low means a word is offered; it is taken only on a
//               posedge where WR#=0 and TXE#=0. Otherwise the word is held.
module ft245_tx #(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 16,
  parameter int SIWU_IDLE = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_en,
  output logic              fifo_ren,
  input  logic [DATA_W-1:0] fifo_rdata,
  input  logic              fifo_rvalid,
  input  logic              fifo_rempty,
  input  logic              ft_txe_n,
  output logic              ft_wr_n,
  output logic [DATA_W-1:0] ft_data,
  output logic              ft_siwu_n,
  output logic              busy,
  output logic [CNT_W-1:0]  tx_cnt
);

  // Registered TXE# so WR# is built from flops only.
  logic              txe_q;
  // Set for the clk in which an accepted read's data is due.
  logic              inflight_q, inflight_d;
  // Skid queue: circular buffer, head at rd_ptr.
  logic [DATA_W-1:0] mem_q [3];
  logic [1:0]        qcnt_q, qcnt_d;
  logic [1:0]        rd_ptr_q, rd_ptr_d;
  logic [1:0]        wr_ptr_q, wr_ptr_d;
  // Output stage presented on the FT245 bus.
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;

  logic              accept;
  logic              push;
  logic              pop;
  logic              load;
  logic              xfer;
  logic              room;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reads are issued only while the queue plus any pending word leaves space
  // for the returning data; nothing from the FT245 pins feeds this path.
  assign room     = ({1'b0, qcnt_q} + {2'b00, inflight_q}) < 3'd3;
  assign fifo_ren = rst_n & tx_en & ~fifo_rempty & room;
  assign accept   = fifo_ren & ~fifo_rempty;
  assign push     = fifo_rvalid;

  assign ft_wr_n  = ~(out_valid_q & ~txe_q);
  assign ft_data  = out_data_q;
  assign xfer     = ~ft_wr_n & ~ft_txe_n;
  assign load     = ~out_valid_q | xfer;
  assign pop      = load & (qcnt_q != 2'd0);
  assign busy     = out_valid_q | (qcnt_q != 2'd0) | inflight_q;
  assign tx_cnt   = tx_cnt_q;

  // Queue bookkeeping and output-stage next state.
  always_comb begin
    inflight_d  = accept;
    qcnt_d      = qcnt_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    tx_cnt_d    = tx_cnt_q;
    case ({push, pop})
      2'b10:   qcnt_d = qcnt_q + 2'd1;
      2'b01:   qcnt_d = qcnt_q - 2'd1;
      default: qcnt_d = qcnt_q;
    endcase
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop) begin
      rd_ptr_d    = ptr_inc(rd_ptr_q);
      out_valid_d = 1'b1;
      out_data_d  = mem_q[rd_ptr_q];
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
    if (xfer) tx_cnt_d = tx_cnt_q + 1'b1;
  end

  // Control and datapath registers; reset discards all buffered words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txe_q       <= 1'b1;
      inflight_q  <= 1'b0;
      qcnt_q      <= 2'd0;
      rd_ptr_q    <= 2'd0;
      wr_ptr_q    <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      tx_cnt_q    <= '0;
    end else begin
      txe_q       <= ft_txe_n;
      inflight_q  <= inflight_d;
      qcnt_q      <= qcnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      tx_cnt_q    <= tx_cnt_d;
    end
  end

  // Queue storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= fifo_rdata;
  end

`ifdef FT245_TX_SIWU_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PULSE} siwu_state_e;
  localparam logic [15:0] SIWU_LAST = 16'(SIWU_IDLE - 1);

  siwu_state_e siwu_state_q, siwu_state_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;

  // Send-immediate state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      siwu_state_q <= S_IDLE;
      idle_cnt_q   <= 16'd0;
    end else begin
      siwu_state_q <= siwu_state_d;
      idle_cnt_q   <= idle_cnt_d;
    end
  end

  // After traffic, wait for SIWU_IDLE consecutive idle clks, then flush.
  always_comb begin
    siwu_state_d = siwu_state_q;
    idle_cnt_d   = idle_cnt_q;
    case (siwu_state_q)
      S_IDLE: begin
        idle_cnt_d = 16'd0;
        if (xfer) siwu_state_d = S_WAIT;
      end
      S_WAIT: begin
        if (xfer || busy) begin
          idle_cnt_d = 16'd0;
        end else if (idle_cnt_q == SIWU_LAST) begin
          idle_cnt_d   = 16'd0;
          siwu_state_d = S_PULSE;
        end else begin
          idle_cnt_d = idle_cnt_q + 16'd1;
        end
      end
      S_PULSE: siwu_state_d = S_IDLE;
      default: siwu_state_d = S_IDLE;
    endcase
  end

  // SIWU# is low only while in PULSE, so the pulse is a single clk wide.
  always_comb begin
    ft_siwu_n = 1'b1;
    if (siwu_state_q == S_PULSE) ft_siwu_n = 1'b0;
  end
`else
  assign ft_siwu_n = 1'b1;
`endif

  // Queue can never overflow given the issue rule.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (qcnt_q == 2'd3)));

  // The FIFO must return data exactly one clk after an accepted read.
  a_rvalid_due : assert property (@(posedge clk) disable iff (!rst_n)
    inflight_q |-> fifo_rvalid);

  // Idle threshold must be within its legal range.
  a_siwu_range : assert property (@(posedge clk)
    (SIWU_IDLE >= 1) && (SIWU_IDLE <= 65535));

endmodule

// File: tb/tb_ft245_tx.sv
// tb_ft245_tx: directed bench for ft245_tx with a behavioural FIFO read
// port, a data scoreboard on every FT245 transfer and a table of bursts.
module tb_ft245_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        tx_en = 1'b0;
  logic        fifo_ren;
  logic [7:0]  fifo_rdata = 8'h00;
  logic        fifo_rvalid = 1'b0;
  logic        fifo_rempty;
  logic        ft_txe_n = 1'b0;
  logic        ft_wr_n;
  logic [7:0]  ft_data;
  logic        ft_siwu_n;
  logic        busy;
  logic [15:0] tx_cnt;

  int checks = 0;
  int errors = 0;

  ft245_tx #(.DATA_W(8), .CNT_W(16), .SIWU_IDLE(4)) dut (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en),
    .fifo_ren(fifo_ren), .fifo_rdata(fifo_rdata), .fifo_rvalid(fifo_rvalid),
    .fifo_rempty(fifo_rempty), .ft_txe_n(ft_txe_n), .ft_wr_n(ft_wr_n),
    .ft_data(ft_data), .ft_siwu_n(ft_siwu_n), .busy(busy), .tx_cnt(tx_cnt)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Behavioural FIFO read port: 1-clk read latency, flushed on reset.
  logic [7:0] fmem [0:255];
  int         wr_idx = 0;
  int         rd_idx = 0;
  logic       will_pop = 1'b0;
  logic [7:0] next_word = 8'h00;

  assign fifo_rempty = (rd_idx == wr_idx);

  always @(negedge clk) will_pop = fifo_ren && !fifo_rempty;

  always @(posedge clk) begin
    if (!rst_n) begin
      fifo_rvalid <= 1'b0;
      rd_idx      <= wr_idx;
    end else if (will_pop) begin
      fifo_rdata  <= fmem[rd_idx];
      fifo_rvalid <= 1'b1;
      rd_idx      <= rd_idx + 1;
    end else begin
      fifo_rvalid <= 1'b0;
    end
  end

  // Scoreboard
  logic [7:0] exp_q [$];
  logic [7:0] exp_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && !ft_wr_n && !ft_txe_n) begin
      if (exp_q.size() == 0) begin
        check("xfer_unexpected", {24'h0, ft_data}, 32'hFFFF_FFFF);
      end else begin
        exp_w = exp_q.pop_front();
        check("xfer_data", {24'h0, ft_data}, {24'h0, exp_w});
      end
    end
  end

  // Driver tasks
  task automatic preload(input int n);
    for (int i = 0; i < n; i++) begin
      fmem[wr_idx] = next_word;
      exp_q.push_back(next_word);
      next_word = next_word + 8'h01;
      wr_idx = wr_idx + 1;
    end
  endtask

  typedef struct {
    int nwords;
    int stall_at;
    int stall_len;
    int exp_first;
    int exp_span;
    int exp_wr_low;
    int exp_nonx;
    int exp_cnt;
  } vec_t;

  vec_t vecs [7];

  task automatic run_vec(input int id, input vec_t v);
    int cyc, first, last, wr_low, nonx, xf, stall_left;
    bit stalled, done;
    cyc = 0; first = -1; last = -1; wr_low = 0; nonx = 0; xf = 0;
    stall_left = 0; stalled = 0; done = 0;
    preload(v.nwords);
    @(posedge clk); #1;
    tx_en = 1'b1;
    while (!done && cyc < 200) begin
      @(negedge clk);
      if (!ft_wr_n) begin
        wr_low++;
        if (first < 0) first = cyc;
        last = cyc;
        if (ft_txe_n) nonx++;
        else xf++;
      end
      if (xf == v.nwords) begin
        done = 1;
      end else begin
        @(posedge clk); #1;
        cyc++;
        if (stall_left > 0) begin
          stall_left--;
          if (stall_left == 0) ft_txe_n = 1'b0;
        end else if (!stalled && v.stall_len > 0 && xf == v.stall_at && !ft_wr_n) begin
          ft_txe_n   = 1'b1;
          stall_left = v.stall_len;
          stalled    = 1;
        end
      end
    end
    check($sformatf("v%0d_done", id), {31'h0, done}, 32'd1);
    @(negedge clk);
    check($sformatf("v%0d_busy_clear", id), {31'h0, busy}, 32'd0);
    check($sformatf("v%0d_ren_empty", id), {31'h0, fifo_ren}, 32'd0);
    check($sformatf("v%0d_tx_cnt", id), {16'h0, tx_cnt}, v.exp_cnt);
    check($sformatf("v%0d_first", id), first, v.exp_first);
    check($sformatf("v%0d_span", id), last - first + 1, v.exp_span);
    check($sformatf("v%0d_wr_low", id), wr_low, v.exp_wr_low);
    check($sformatf("v%0d_nonxfer", id), nonx, v.exp_nonx);
    @(posedge clk); #1;
    tx_en = 1'b0;
  endtask

  int xf, n, acc, ren_seen, maxq, first_low, lows;
  bit done;

  initial begin
    // {nwords, stall_at, stall_len, first, span, wr_low, nonxfer, tx_cnt}
    vecs[0] = '{16, 0, 0, 3, 16, 16, 0, 16};
    vecs[1] = '{ 8, 3, 4, 3, 13,  9, 1, 24};
    vecs[2] = '{ 1, 0, 0, 3,  1,  1, 0, 25};
    vecs[3] = '{ 5, 0, 2, 3,  8,  6, 1, 30};
    vecs[4] = '{ 6, 5, 1, 3,  8,  7, 1, 36};
    vecs[5] = '{ 4, 2, 3, 3,  8,  5, 1, 40};
    vecs[6] = '{ 3, 0, 0, 3,  3,  3, 0,  3};

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_ren", {31'h0, fifo_ren}, 32'd0);
    check("rst_wr_n", {31'h0, ft_wr_n}, 32'd1);
    check("rst_data", {24'h0, ft_data}, 32'd0);
    check("rst_siwu_n", {31'h0, ft_siwu_n}, 32'd1);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_tx_cnt", {16'h0, tx_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Table of bursts, with and without TXE# stalls
    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Empty FIFO, then a single word
    @(posedge clk); #1 tx_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("empty_ren", {31'h0, fifo_ren}, 32'd0);
      check("empty_busy", {31'h0, busy}, 32'd0);
    end
    @(posedge clk); #1 preload(1);
    xf = 0; n = 0; maxq = 0;
    while (xf < 1 && n < 20) begin
      @(negedge clk);
      if (int'(dut.qcnt_q) > maxq) maxq = int'(dut.qcnt_q);
      if (!ft_wr_n && !ft_txe_n) xf++;
      n++;
    end
    check("single_xfer", xf, 1);
    @(negedge clk);
    check("single_qmax_le1", {31'h0, maxq <= 1}, 32'd1);
    check("single_ren_off", {31'h0, fifo_ren}, 32'd0);
    check("single_busy", {31'h0, busy}, 32'd0);
    check("single_tx_cnt", {16'h0, tx_cnt}, 32'd41);
    @(posedge clk); #1 tx_en = 1'b0;

    // tx_en dropped after two accepted reads with plenty queued in the FIFO
    preload(10);
    @(posedge clk); #1 tx_en = 1'b1;
    acc = 0; n = 0;
    while (acc < 2 && n < 10) begin
      @(negedge clk);
      if (fifo_ren && !fifo_rempty) acc++;
      n++;
    end
    check("drop_accepts", acc, 2);
    @(posedge clk); #1 tx_en = 1'b0;
    xf = 0; n = 0; ren_seen = 0; done = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      if (fifo_ren) ren_seen++;
      if (!ft_wr_n && !ft_txe_n) xf++;
      if (!busy) done = 1;
      n++;
    end
    check("drop_busy_clear", {31'h0, done}, 32'd1);
    check("drop_xfers", xf, 2);
    check("drop_ren_off", ren_seen, 0);
    check("drop_tx_cnt", {16'h0, tx_cnt}, 32'd43);

    // Reset asserted mid-burst
    @(posedge clk); #1 tx_en = 1'b1;
    xf = 0; n = 0;
    while (xf < 3 && n < 30) begin
      @(negedge clk);
      if (!ft_wr_n && !ft_txe_n) xf++;
      n++;
    end
    check("mid_pre_xfers", xf, 3);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("mid_rst_wr_n", {31'h0, ft_wr_n}, 32'd1);
    check("mid_rst_ren", {31'h0, fifo_ren}, 32'd0);
    check("mid_rst_data", {24'h0, ft_data}, 32'd0);
    check("mid_rst_busy", {31'h0, busy}, 32'd0);
    check("mid_rst_tx_cnt", {16'h0, tx_cnt}, 32'd0);
    check("mid_rst_siwu_n", {31'h0, ft_siwu_n}, 32'd1);
    tx_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_cnt", {16'h0, tx_cnt}, 32'd0);
    check("post_rst_wr_n", {31'h0, ft_wr_n}, 32'd1);

    // Clean burst after reset
    run_vec(6, vecs[6]);

`ifdef FT245_TX_SIWU_EN
    // Send-immediate pulse after a short burst goes idle
    repeat (10) @(posedge clk);
    #1 preload(3);
    @(posedge clk); #1 tx_en = 1'b1;
    xf = 0; n = 0;
    while (xf < 3 && n < 40) begin
      @(negedge clk);
      if (!ft_wr_n && !ft_txe_n) xf++;
      n++;
    end
    check("siwu_burst", xf, 3);
    @(negedge clk);
    check("siwu_busy_fall", {31'h0, busy}, 32'd0);
    first_low = -1; lows = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (!ft_siwu_n) begin
        lows++;
        if (first_low < 0) first_low = i;
      end
    end
    check("siwu_delay", first_low, 4);
    check("siwu_width", lows, 1);
    @(posedge clk); #1 tx_en = 1'b0;
`endif

    repeat (2) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
